// File: rtl/epl_ecc_pkg.sv
// Shared constants for the EPL Hamming(7,4) inverted-parity code.
// The encoder and decoder both import this package so they agree on the bit layout.
package epl_ecc_pkg;

  localparam int CW_W  = 7;
  localparam int DW_W  = 4;
  localparam int SYN_W = 3;

  // Codeword bit positions, layout {d3,d2,d1,p4,d0,p2,p1}
  localparam int BIT_P1 = 0;
  localparam int BIT_P2 = 1;
  localparam int BIT_D0 = 2;
  localparam int BIT_P4 = 3;
  localparam int BIT_D1 = 4;
  localparam int BIT_D2 = 5;
  localparam int BIT_D3 = 6;

  localparam logic PARITY_INV = 1'b1;

  typedef struct packed {
    logic             valid;
    logic [CW_W-1:0]  cw;
    logic [SYN_W-1:0] syn;
    logic [CW_W-1:0]  mask;
  } stage1_t;

  function automatic logic [DW_W-1:0] extract_data(input logic [CW_W-1:0] cw);
    return {cw[BIT_D3], cw[BIT_D2], cw[BIT_D1], cw[BIT_D0]};
  endfunction

endpackage

// File: rtl/epl_ecc_syndrome.sv
// Combinational syndrome and single-bit correction mask for one codeword.
// A non-zero syndrome is the 1-based position of the bit to flip.
module epl_ecc_syndrome
  import epl_ecc_pkg::*;
(
  input  logic [CW_W-1:0]  codeword_i,
  output logic [SYN_W-1:0] syndrome_o,
  output logic [CW_W-1:0]  mask_o
);

  logic s1, s2, s4;

  assign s1 = codeword_i[BIT_P1] ^ codeword_i[BIT_D0] ^ codeword_i[BIT_D1]
            ^ codeword_i[BIT_D3] ^ PARITY_INV;
  assign s2 = codeword_i[BIT_P2] ^ codeword_i[BIT_D0] ^ codeword_i[BIT_D2]
            ^ codeword_i[BIT_D3] ^ PARITY_INV;
  assign s4 = codeword_i[BIT_P4] ^ codeword_i[BIT_D1] ^ codeword_i[BIT_D2]
            ^ codeword_i[BIT_D3] ^ PARITY_INV;

  assign syndrome_o = {s4, s2, s1};

  always_comb begin
    // NOTE: default first so every path assigns mask_o and no latch is inferred.
    mask_o = '0;
    if (syndrome_o != '0) begin
      mask_o = CW_W'(1) << (syndrome_o - SYN_W'(1));
    end
  end

endmodule

// File: rtl/epl_ecc_decoder.sv
// EPL Hamming(7,4) read-path decoder: 2-stage pipeline with single-bit correction,
// sticky error flag and saturating corrected-word counter.
module epl_ecc_decoder
  import epl_ecc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              pCLK_i,
  input  logic              nRST_i,
  input  logic              pREAD_i,
  input  logic [CW_W-1:0]   pCODEWORD_i,
  input  logic              pCLR_i,
  output logic [DW_W-1:0]   pDATA_o,
  output logic              pVALID_o,
  output logic [SYN_W-1:0]  pSYNDROME_o,
  output logic              pCORR_o,
  output logic              pSTICKY_o,
  output logic [CNT_W-1:0]  pERRCNT_o
);

  logic [SYN_W-1:0] syn_w;
  logic [CW_W-1:0]  mask_w;

  epl_ecc_syndrome u_syndrome (
    .codeword_i (pCODEWORD_i),
    .syndrome_o (syn_w),
    .mask_o     (mask_w)
  );

  stage1_t          s1_d, s1_q;
  logic [DW_W-1:0]  data_d, data_q;
  logic [SYN_W-1:0] syn_d, syn_q;
  logic             corr_d, corr_q;
  logic             valid_d, valid_q;
  logic             sticky_d, sticky_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             hit;

  // Idle cycles clear stage 1 so no stale codeword lingers in the pipeline.
  always_comb begin
    s1_d = '0;
    if (pREAD_i) begin
      s1_d.valid = 1'b1;
      s1_d.cw    = pCODEWORD_i;
      s1_d.syn   = syn_w;
      s1_d.mask  = mask_w;
    end
  end

  always_comb begin
    data_d  = '0;
    syn_d   = '0;
    corr_d  = 1'b0;
    valid_d = s1_q.valid;
    if (s1_q.valid) begin
      data_d = extract_data(s1_q.cw ^ s1_q.mask);
      syn_d  = s1_q.syn;
      corr_d = (s1_q.syn != '0);
    end
  end

  assign hit = s1_q.valid && (s1_q.syn != '0);

  // Clear wins over a correction landing in the same cycle.
  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (pCLR_i) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (hit) begin
      sticky_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge pCLK_i or negedge nRST_i) begin
    if (!nRST_i) begin
      s1_q     <= '0;
      data_q   <= '0;
      syn_q    <= '0;
      corr_q   <= 1'b0;
      valid_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      data_q   <= data_d;
      syn_q    <= syn_d;
      corr_q   <= corr_d;
      valid_q  <= valid_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pDATA_o     = data_q;
  assign pVALID_o    = valid_q;
  assign pSYNDROME_o = syn_q;
  assign pCORR_o     = corr_q;
  assign pSTICKY_o   = sticky_q;
  assign pERRCNT_o   = cnt_q;

endmodule

// File: tb/tb_epl_ecc_decoder.sv
// Scoreboard bench for epl_ecc_decoder, built with a 2-bit counter to reach saturation.
module tb_epl_ecc_decoder;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             pCLK_i = 1'b0;
  logic             nRST_i = 1'b0;
  logic             pREAD_i = 1'b0;
  logic [6:0]       pCODEWORD_i = '0;
  logic             pCLR_i = 1'b0;
  logic [3:0]       pDATA_o;
  logic             pVALID_o;
  logic [2:0]       pSYNDROME_o;
  logic             pCORR_o;
  logic             pSTICKY_o;
  logic [CNT_W-1:0] pERRCNT_o;

  epl_ecc_decoder #(.CNT_W(CNT_W)) dut (
    .pCLK_i      (pCLK_i),
    .nRST_i      (nRST_i),
    .pREAD_i     (pREAD_i),
    .pCODEWORD_i (pCODEWORD_i),
    .pCLR_i      (pCLR_i),
    .pDATA_o     (pDATA_o),
    .pVALID_o    (pVALID_o),
    .pSYNDROME_o (pSYNDROME_o),
    .pCORR_o     (pCORR_o),
    .pSTICKY_o   (pSTICKY_o),
    .pERRCNT_o   (pERRCNT_o)
  );

  always #5 pCLK_i = ~pCLK_i;

  typedef struct {
    logic [3:0] data;
    logic [2:0] syn;
    logic       corr;
    int         due;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   m_cnt   = 0;
  logic m_sticky = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference encoder with inverted parity, layout {d3,d2,d1,p4,d0,p2,p1}
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = ~(d[0] ^ d[1] ^ d[3]);
    p2 = ~(d[0] ^ d[2] ^ d[3]);
    p4 = ~(d[1] ^ d[2] ^ d[3]);
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  // One clock: drive inputs, push expectation on a read, check every output after the edge.
  task automatic tick(input logic rd, input logic [6:0] cw, input logic clr,
                      input logic [3:0] ed, input logic [2:0] es);
    exp_t e;
    logic hit;
    pREAD_i     = rd;
    pCODEWORD_i = cw;
    pCLR_i      = clr;
    @(posedge pCLK_i);
    cyc++;
    if (rd) begin
      e.data = ed;
      e.syn  = es;
      e.corr = (es != 3'd0);
      e.due  = cyc + 1;
      q.push_back(e);
    end
    #1;
    hit = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check("valid", 32'(pVALID_o), 32'd1);
      check("data", 32'(pDATA_o), 32'(e.data));
      check("syndrome", 32'(pSYNDROME_o), 32'(e.syn));
      check("corr", 32'(pCORR_o), 32'(e.corr));
      hit = e.corr;
    end else begin
      check("idle_valid", 32'(pVALID_o), 32'd0);
      check("idle_data", 32'(pDATA_o), 32'd0);
      check("idle_syndrome", 32'(pSYNDROME_o), 32'd0);
      check("idle_corr", 32'(pCORR_o), 32'd0);
    end
    if (clr) begin
      m_cnt    = 0;
      m_sticky = 1'b0;
    end else if (hit) begin
      m_sticky = 1'b1;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    check("errcnt", 32'(pERRCNT_o), 32'(m_cnt));
    check("sticky", 32'(pSTICKY_o), 32'(m_sticky));
    pREAD_i = 1'b0;
    pCLR_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 7'h00, 1'b0, 4'h0, 3'd0);
  endtask

  initial begin
    logic [6:0] cw;

    // Reset state
    repeat (2) @(posedge pCLK_i);
    #1;
    check("rst_valid", 32'(pVALID_o), 32'd0);
    check("rst_data", 32'(pDATA_o), 32'd0);
    check("rst_errcnt", 32'(pERRCNT_o), 32'd0);
    check("rst_sticky", 32'(pSTICKY_o), 32'd0);
    nRST_i = 1'b1;

    // Clean words back-to-back
    tick(1'b1, 7'h59, 1'b0, 4'hA, 3'd0);
    tick(1'b1, 7'h0B, 1'b0, 4'h0, 3'd0);
    tick(1'b1, 7'h74, 1'b0, 4'hF, 3'd0);
    idle(2);

    // Single data-bit error and parity-bit error
    tick(1'b1, 7'h79, 1'b0, 4'hA, 3'd6);
    idle(2);
    tick(1'b1, 7'h0A, 1'b0, 4'h0, 3'd1);
    // All-zero codeword is illegal and decodes as S=7
    tick(1'b1, 7'h00, 1'b0, 4'h8, 3'd7);
    idle(2);

    // Every single-bit flip of every codeword, back-to-back
    for (int d = 0; d < 16; d++) begin
      cw = enc(4'(d));
      tick(1'b1, cw, 1'b0, 4'(d), 3'd0);
      for (int k = 0; k < 7; k++) begin
        tick(1'b1, cw ^ (7'(1) << k), 1'b0, 4'(d), 3'(k + 1));
      end
    end
    idle(2);

    // Saturation, then a clear coinciding with a correction
    tick(1'b0, 7'h00, 1'b1, 4'h0, 3'd0);
    for (int i = 0; i < 5; i++) tick(1'b1, 7'h79, 1'b0, 4'hA, 3'd6);
    tick(1'b1, 7'h79, 1'b0, 4'hA, 3'd6);
    tick(1'b0, 7'h00, 1'b1, 4'h0, 3'd0);
    idle(2);

    // Idle with an erroneous word on the bus
    tick(1'b0, 7'h79, 1'b0, 4'h0, 3'd0);
    tick(1'b0, 7'h79, 1'b0, 4'h0, 3'd0);
    idle(1);

    // Reset mid-flight
    tick(1'b1, 7'h79, 1'b0, 4'hA, 3'd6);
    tick(1'b1, 7'h74, 1'b0, 4'hF, 3'd0);
    #2;
    nRST_i = 1'b0;
    #1;
    check("midrst_valid", 32'(pVALID_o), 32'd0);
    check("midrst_data", 32'(pDATA_o), 32'd0);
    check("midrst_syndrome", 32'(pSYNDROME_o), 32'd0);
    check("midrst_corr", 32'(pCORR_o), 32'd0);
    check("midrst_errcnt", 32'(pERRCNT_o), 32'd0);
    check("midrst_sticky", 32'(pSTICKY_o), 32'd0);
    q.delete();
    m_cnt    = 0;
    m_sticky = 1'b0;
    @(posedge pCLK_i);
    cyc++;
    #1;
    nRST_i = 1'b1;
    idle(4);

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
